// File: rtl/pc_thr_sel_if.sv
// pc_thr_sel_if: thread-select control inputs and fetch-stage outputs bundle
interface pc_thr_sel_if;
    logic [3:0]  thr_run;
    logic        fetch_stall;
    logic        redirect_vld;
    logic [1:0]  redirect_thr;
    logic [47:0] redirect_pc;
    logic [47:0] pc_f;
    logic [3:0]  thr_f;
    logic        inst_vld_f;
    logic [47:0] t0pc_f;
    logic [47:0] t1pc_f;
    logic [47:0] t2pc_f;
    logic [47:0] t3pc_f;
    logic [15:0] sw_cnt;
    modport master(
        output thr_run, fetch_stall, redirect_vld, redirect_thr, redirect_pc,
        input  pc_f, thr_f, inst_vld_f, t0pc_f, t1pc_f, t2pc_f, t3pc_f, sw_cnt
    );
    modport slave(
        input  thr_run, fetch_stall, redirect_vld, redirect_thr, redirect_pc,
        output pc_f, thr_f, inst_vld_f, t0pc_f, t1pc_f, t2pc_f, t3pc_f, sw_cnt
    );
endinterface

// File: rtl/pc_thr_sel.sv
// pc_thr_sel: 4-thread round-robin fetch thread select with per-thread PCs; PC_THR_SEL_SWITCH_CNT_EN adds a switch counter
module pc_thr_sel #(
    parameter logic [47:0] RESET_PC = 48'h0000_0000_0020
) (
    input logic         clk,
    input logic         rst,
    pc_thr_sel_if.slave bus
);
    logic [47:0] r_tpc [4];
    logic [47:0] r_pc_f;
    logic [3:0]  r_thr_f;
    logic        r_vld;
    logic [1:0]  r_last;
    logic        w_adv;
    logic        w_squash;
    logic [47:0] w_nxt [4];
    logic [1:0]  w_sel;
    logic        w_sel_vld;

    assign w_adv    = r_vld & ~bus.fetch_stall;
    assign w_squash = bus.redirect_vld & r_vld & r_thr_f[bus.redirect_thr];

    genvar n;
    generate
        for (n = 0; n < 4; n++) begin : g_nxt
            assign w_nxt[n] = (bus.redirect_vld && bus.redirect_thr == 2'(n)) ? (bus.redirect_pc & ~48'd3)
                            : (w_adv && r_thr_f[n]) ? r_tpc[n] + 48'd4 : r_tpc[n];
        end
    endgenerate

    // round-robin pick: scan farthest-to-nearest from last_thr so the nearest runnable thread wins
    always_comb begin
        w_sel     = r_last;
        w_sel_vld = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (bus.thr_run[r_last + 2'(k)]) begin
                w_sel     = r_last + 2'(k);
                w_sel_vld = 1'b1;
            end
        end
    end

    // per-thread PCs always follow nxt; F stage loads on selection, holds on stall unless squashed
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_tpc[i] <= RESET_PC;
            r_pc_f  <= RESET_PC;
            r_thr_f <= 4'b0;
            r_vld   <= 1'b0;
            r_last  <= 2'd3;
        end else begin
            for (int i = 0; i < 4; i++) r_tpc[i] <= w_nxt[i];
            if (!bus.fetch_stall) begin
                r_vld   <= w_sel_vld;
                r_thr_f <= w_sel_vld ? 4'b1 << w_sel : 4'b0;
                if (w_sel_vld) begin
                    r_pc_f <= w_nxt[w_sel];
                    r_last <= w_sel;
                end
            end else if (w_squash) begin
                r_vld   <= 1'b0;
                r_thr_f <= 4'b0;
            end
        end
    end

    assign bus.pc_f       = r_pc_f;
    assign bus.thr_f      = r_thr_f;
    assign bus.inst_vld_f = r_vld;
    assign bus.t0pc_f     = r_tpc[0];
    assign bus.t1pc_f     = r_tpc[1];
    assign bus.t2pc_f     = r_tpc[2];
    assign bus.t3pc_f     = r_tpc[3];

`ifdef PC_THR_SEL_SWITCH_CNT_EN
    logic [15:0] r_sw_cnt;
    logic        r_sel_seen;

    // count selections that change thread; the first selection after reset has no predecessor
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_cnt   <= 16'd0;
            r_sel_seen <= 1'b0;
        end else if (!bus.fetch_stall && w_sel_vld) begin
            r_sel_seen <= 1'b1;
            if (r_sel_seen && w_sel != r_last && r_sw_cnt != 16'hFFFF) r_sw_cnt <= r_sw_cnt + 16'd1;
        end
    end

    assign bus.sw_cnt = r_sw_cnt;
`else
    assign bus.sw_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_pc_thr_sel.sv
// tb_pc_thr_sel: directed vectors pushed to a scoreboard queue, checked by a negedge monitor
module tb_pc_thr_sel;
    typedef struct {
        logic [47:0] pc;
        logic [3:0]  thr;
        logic        vld;
        int          ti;
        logic [47:0] tv;
        logic [15:0] sw;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    pc_thr_sel_if bus();

    pc_thr_sel #(.RESET_PC(48'h0000_0000_0020)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [47:0] tpc_of(input int i);
        return i == 0 ? bus.t0pc_f : i == 1 ? bus.t1pc_f : i == 2 ? bus.t2pc_f : bus.t3pc_f;
    endfunction

    // monitor: compare each registered response and the pc_f/tNpc_f invariant
    always @(negedge clk) begin
        exp_t e;
        logic [47:0] inv;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_f", bus.pc_f, e.pc);
            chk("thr_f", {44'd0, bus.thr_f}, {44'd0, e.thr});
            chk("inst_vld_f", {47'd0, bus.inst_vld_f}, {47'd0, e.vld});
            chk($sformatf("t%0dpc_f", e.ti), tpc_of(e.ti), e.tv);
            chk("sw_cnt", {32'd0, bus.sw_cnt}, {32'd0, e.sw});
        end
        if (bus.inst_vld_f) begin
            inv = bus.thr_f == 4'b0001 ? bus.t0pc_f : bus.thr_f == 4'b0010 ? bus.t1pc_f
                : bus.thr_f == 4'b0100 ? bus.t2pc_f : bus.thr_f == 4'b1000 ? bus.t3pc_f : ~bus.pc_f;
            chk("invariant", bus.pc_f, inv);
        end
    end

    task automatic step(input logic r, input logic [3:0] run, input logic st,
                        input logic rv, input logic [1:0] rt, input logic [47:0] rp,
                        input logic [47:0] pc, input logic [3:0] thr, input logic vld,
                        input int ti, input logic [47:0] tv, input logic [15:0] sw);
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus.thr_run      = run;
        bus.fetch_stall  = st;
        bus.redirect_vld = rv;
        bus.redirect_thr = rt;
        bus.redirect_pc  = rp;
        @(posedge clk);
`ifdef PC_THR_SEL_SWITCH_CNT_EN
        e = '{pc, thr, vld, ti, tv, sw};
`else
        e = '{pc, thr, vld, ti, tv, 16'd0};
`endif
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.thr_run      = 4'b0;
        bus.fetch_stall  = 1'b0;
        bus.redirect_vld = 1'b0;
        bus.redirect_thr = 2'd0;
        bus.redirect_pc  = 48'd0;
        //   rst run     stl rv rt    rpc                   pc_f                  thr     vld ti tNpc_f               sw
        step(1, 4'b0000, 0, 0, 2'd0, 48'h0,                48'h20,               4'b0000, 0, 0, 48'h20,               0);
        step(0, 4'b0001, 0, 0, 2'd0, 48'h0,                48'h20,               4'b0001, 1, 0, 48'h20,               0);
        step(0, 4'b0001, 0, 0, 2'd0, 48'h0,                48'h24,               4'b0001, 1, 0, 48'h24,               0);
        step(0, 4'b0001, 0, 0, 2'd0, 48'h0,                48'h28,               4'b0001, 1, 0, 48'h28,               0);
        step(0, 4'b0001, 1, 0, 2'd0, 48'h0,                48'h28,               4'b0001, 1, 0, 48'h28,               0);
        step(0, 4'b0001, 1, 0, 2'd0, 48'h0,                48'h28,               4'b0001, 1, 0, 48'h28,               0);
        step(0, 4'b0001, 1, 0, 2'd0, 48'h0,                48'h28,               4'b0001, 1, 0, 48'h28,               0);
        step(0, 4'b0001, 0, 0, 2'd0, 48'h0,                48'h2C,               4'b0001, 1, 0, 48'h2C,               0);
        step(0, 4'b0000, 0, 0, 2'd0, 48'h0,                48'h2C,               4'b0000, 0, 0, 48'h30,               0);
        step(1, 4'b0000, 0, 0, 2'd0, 48'h0,                48'h20,               4'b0000, 0, 0, 48'h20,               0);
        step(0, 4'b1111, 0, 0, 2'd0, 48'h0,                48'h20,               4'b0001, 1, 0, 48'h20,               0);
        step(0, 4'b1111, 0, 0, 2'd0, 48'h0,                48'h20,               4'b0010, 1, 0, 48'h24,               1);
        step(0, 4'b1111, 0, 0, 2'd0, 48'h0,                48'h20,               4'b0100, 1, 1, 48'h24,               2);
        step(0, 4'b1111, 0, 0, 2'd0, 48'h0,                48'h20,               4'b1000, 1, 2, 48'h24,               3);
        step(0, 4'b1111, 0, 0, 2'd0, 48'h0,                48'h24,               4'b0001, 1, 3, 48'h24,               4);
        step(0, 4'b1111, 0, 0, 2'd0, 48'h0,                48'h24,               4'b0010, 1, 0, 48'h28,               5);
        step(0, 4'b1111, 0, 1, 2'd2, 48'h1234_5678_9ABF,   48'h1234_5678_9ABC,   4'b0100, 1, 2, 48'h1234_5678_9ABC,   6);
        step(1, 4'b1111, 0, 0, 2'd0, 48'h0,                48'h20,               4'b0000, 0, 2, 48'h20,               0);
        step(0, 4'b1111, 0, 0, 2'd0, 48'h0,                48'h20,               4'b0001, 1, 3, 48'h20,               0);
        step(0, 4'b0010, 0, 0, 2'd0, 48'h0,                48'h20,               4'b0010, 1, 0, 48'h24,               1);
        step(0, 4'b0010, 1, 1, 2'd1, 48'h400,              48'h20,               4'b0000, 0, 1, 48'h400,              1);
        step(0, 4'b0010, 0, 0, 2'd0, 48'h0,                48'h400,              4'b0010, 1, 1, 48'h400,              1);
        step(0, 4'b0010, 0, 1, 2'd1, 48'hFFFF_FFFF_FFFF,   48'hFFFF_FFFF_FFFC,   4'b0010, 1, 1, 48'hFFFF_FFFF_FFFC,   1);
        step(0, 4'b0010, 0, 0, 2'd0, 48'h0,                48'h0,                4'b0010, 1, 1, 48'h0,                1);
        step(0, 4'b0001, 0, 0, 2'd0, 48'h0,                48'h24,               4'b0001, 1, 1, 48'h4,                2);
        step(0, 4'b0001, 1, 1, 2'd3, 48'h100,              48'h24,               4'b0001, 1, 3, 48'h100,              2);
        step(0, 4'b1000, 0, 0, 2'd0, 48'h0,                48'h100,              4'b1000, 1, 0, 48'h28,               3);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_thr_sel.md
PC_THR_SEL -- requirements
Module: pc_thr_sel

Interface
REQ-001 SHALL have parameter RESET_PC, default 48'h0000_0000_0020, meaning the fetch PC loaded into every thread on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port thr_run  input  4  per-thread run enable; bit N set means thread N is eligible for selection.
REQ-005 SHALL have port fetch_stall  input  1  downstream stall; holds the F-stage.
REQ-006 SHALL have port redirect_vld  input  1  redirect request this cycle.
REQ-007 SHALL have port redirect_thr  input  2  thread index of the redirect.
REQ-008 SHALL have port redirect_pc  input  48  redirect target; bits [1:0] ignored and stored as 2'b00.
REQ-009 SHALL have port pc_f  output  48  fetch PC of the instruction in F.
REQ-010 SHALL have port thr_f  output  4  one-hot thread in F; all zero when F is empty.
REQ-011 SHALL have port inst_vld_f  output  1  F holds a valid fetch.
REQ-012 SHALL have ports t0pc_f, t1pc_f, t2pc_f, t3pc_f  output  48 each  per-thread current fetch PC registers.
REQ-013 SHALL have port sw_cnt  output  16  thread-switch count (see Configuration).

Function
REQ-014 SHALL compute per thread N: nxt_N = redirect_pc&~3 if redirect_vld and redirect_thr==N; else tNpc_f+4 (mod 2^48) if advance and thr_f[N]; else tNpc_f; advance = inst_vld_f & ~fetch_stall.
REQ-015 SHALL update tNpc_f <= nxt_N every cycle; redirect has priority over increment.
REQ-016 SHALL, when fetch_stall=0, select the next thread round-robin among thr_run bits, searching from last_thr+1 upward modulo 4; last_thr updates only when a thread is selected.
REQ-017 SHALL, on selection of thread N, load thr_f <= one-hot(N), pc_f <= nxt_N, inst_vld_f <= 1 (one-cycle latency, back-to-back allowed on the same thread).
REQ-018 SHALL, when fetch_stall=0 and thr_run==0, load inst_vld_f <= 0, thr_f <= 0, pc_f held.
REQ-019 SHALL, when fetch_stall=1, hold pc_f, thr_f, inst_vld_f and last_thr, except REQ-020.
REQ-020 SHALL squash: if redirect_vld targets the thread in F (inst_vld_f & thr_f[redirect_thr]) while fetch_stall=1, load inst_vld_f <= 0 and thr_f <= 0.
REQ-021 SHALL guarantee invariant: whenever inst_vld_f=1, pc_f equals tNpc_f of the thread set in thr_f.
REQ-022 SHALL let a thread whose thr_run bit drops while in F complete normally (no squash).

Reset
REQ-023 SHALL, on rst=1 at a rising edge, set t0pc_f..t3pc_f = RESET_PC, pc_f = RESET_PC, thr_f = 0, inst_vld_f = 0, last_thr = 3 (T0 selected first), sw_cnt = 0.
REQ-024 SHALL give rst priority over redirect, stall and selection; reset mid-operation discards the in-flight fetch.

Configuration
REQ-025 SHALL compile the switch counter only when macro PC_THR_SEL_SWITCH_CNT_EN is defined.
REQ-026 SHALL, with PC_THR_SEL_SWITCH_CNT_EN, increment sw_cnt on each selection whose thread differs from the previously selected thread, saturating at 16'hFFFF.
REQ-027 SHALL, without PC_THR_SEL_SWITCH_CNT_EN, drive sw_cnt constant 0 and instantiate no counter state.

Verification
REQ-028 SHALL cover: reset, thr_run=4'b0001, no stall, 3 cycles -> pc_f = 0x20, 0x24, 0x28; thr_f=4'b0001; t0pc_f tracks pc_f.
REQ-029 SHALL cover: thr_run=4'b1111 from reset -> thr_f sequence 0001,0010,0100,1000,0001; each pc_f = 0x20 first visit, 0x24 second visit of T0; sw_cnt=4 after 5 selections (macro on), 0 (macro off).
REQ-030 SHALL cover: T0 in F, fetch_stall=1 for 3 cycles -> outputs frozen, t0pc_f unchanged; release -> T0 advances by 4 exactly once.
REQ-031 SHALL cover: redirect_thr=2, redirect_pc=48'h1234_5678_9ABF while T2 selected same cycle -> pc_f = t2pc_f = 48'h1234_5678_9ABC next cycle.
REQ-032 SHALL cover: T1 in F with fetch_stall=1, redirect_thr=1 to 0x400 -> next cycle inst_vld_f=0, thr_f=0, t1pc_f=0x400; t1pc_f=48'hFFFF_FFFF_FFFC advanced -> wraps to 0.
REQ-033 SHALL cover: rst asserted while thr_f=4'b0100 valid -> next cycle inst_vld_f=0, all tNpc_f = RESET_PC, first selection T0; bench checks REQ-021 every cycle.
